// File: rtl/dpram_b_arb.sv
// Port-B arbiter for the dual-port halfword BRAM: shares one read/write port between the
// load/store unit (M0) and the debug loader (M1), and routes 1-cycle read data back.
module dpram_b_arb #(
   parameter int unsigned NUM_COL    = 2,
   parameter int unsigned COL_WIDTH  = 8,
   parameter int unsigned ADDR_WIDTH = 13,
   parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  m0_req,
   input  logic [NUM_COL-1:0]    m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,

   input  logic                  m1_req,
   input  logic [NUM_COL-1:0]    m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m1_rdata,

   output logic                  enaB,
   output logic [NUM_COL-1:0]    weB,
   output logic [ADDR_WIDTH-1:0] addrB,
   output logic [DATA_WIDTH-1:0] dinB,
   input  logic [DATA_WIDTH-1:0] doutB
);

   localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

   logic [3:0] burst_q, burst_d;
   logic       rd_pend_q, rd_pend_d;
   logic       rd_src_q, rd_src_d;

   // Grant: M0 wins contention until it has taken MAX_BURST contested slots in a row.
   always_comb begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
      if (!rst) begin
         if (m0_req && m1_req) begin
            m1_gnt = (burst_q == MaxBurst);
            m0_gnt = !m1_gnt;
         end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
         end
      end
   end

   always_comb begin
      enaB  = m0_gnt | m1_gnt;
      weB   = '0;
      addrB = '0;
      dinB  = '0;
      if (m0_gnt) begin
         weB   = m0_we;
         addrB = m0_addr;
         dinB  = m0_wdata;
      end else if (m1_gnt) begin
         weB   = m1_we;
         addrB = m1_addr;
         dinB  = m1_wdata;
      end
   end

   always_comb begin
      burst_d = burst_q;
      if (m1_gnt || !m1_req) begin
         burst_d = 4'd0;
      end else if (m0_gnt) begin
         burst_d = burst_q + 4'd1;
      end
   end

   always_comb begin
      rd_pend_d = (m0_gnt && (m0_we == '0)) || (m1_gnt && (m1_we == '0));
      rd_src_d  = rd_src_q;
      if (m1_gnt) begin
         rd_src_d = 1'b1;
      end else if (m0_gnt) begin
         rd_src_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         burst_q   <= 4'd0;
         rd_pend_q <= 1'b0;
         rd_src_q  <= 1'b0;
      end else begin
         burst_q   <= burst_d;
         rd_pend_q <= rd_pend_d;
         rd_src_q  <= rd_src_d;
      end
   end

   // Read data is steered to the issuing master only; the other side sees zero.
   always_comb begin
      m0_rvalid = rd_pend_q && !rd_src_q;
      m1_rvalid = rd_pend_q && rd_src_q;
      m0_rdata  = m0_rvalid ? doutB : '0;
      m1_rdata  = m1_rvalid ? doutB : '0;
   end

   a_one_gnt : assert property (@(posedge clk) disable iff (rst) !(m0_gnt && m1_gnt));
   a_one_rv  : assert property (@(posedge clk) disable iff (rst) !(m0_rvalid && m1_rvalid));

endmodule

// File: tb/tb_dpram_b_arb.sv
// Bench for dpram_b_arb: behavioural RAM, a transaction-level reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_dpram_b_arb;

   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m1_req;
   logic [1:0]  m0_we, m1_we;
   logic [12:0] m0_addr, m1_addr;
   logic [15:0] m0_wdata, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [15:0] m0_rdata, m1_rdata;
   logic        enaB;
   logic [1:0]  weB;
   logic [12:0] addrB;
   logic [15:0] dinB;
   logic [15:0] doutB = 16'h0;

   int errs = 0;
   int checks = 0;

   dpram_b_arb dut (
      .clk      (clk),
      .rst      (rst),
      .m0_req   (m0_req),
      .m0_we    (m0_we),
      .m0_addr  (m0_addr),
      .m0_wdata (m0_wdata),
      .m0_gnt   (m0_gnt),
      .m0_rvalid(m0_rvalid),
      .m0_rdata (m0_rdata),
      .m1_req   (m1_req),
      .m1_we    (m1_we),
      .m1_addr  (m1_addr),
      .m1_wdata (m1_wdata),
      .m1_gnt   (m1_gnt),
      .m1_rvalid(m1_rvalid),
      .m1_rdata (m1_rdata),
      .enaB     (enaB),
      .weB      (weB),
      .addrB    (addrB),
      .dinB     (dinB),
      .doutB    (doutB)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                         input logic [1:0] be);
      logic [15:0] r;
      r = old;
      for (int l = 0; l < 2; l++) if (be[l]) r[l*8 +: 8] = nw[l*8 +: 8];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Block RAM, no-change mode.
   logic [15:0] ram [0:8191];
   always @(posedge clk) begin
      if (enaB) begin
         if (weB == 2'b00) doutB <= ram[addrB];
         else              ram[addrB] <= merge(ram[addrB], dinB, weB);
      end
   end

   // Reference model: mb counts contested M0 wins since M1 last won or went idle.
   logic [15:0] mmem [0:8191];
   int          mb;
   logic        ev0, ev1;
   logic [15:0] ed0, ed1;
   logic        e_g0, e_g1;

   always_comb begin
      e_g0 = 1'b0;
      e_g1 = 1'b0;
      if (!rst) begin
         if (m0_req && m1_req) begin
            if (mb == MAXB) e_g1 = 1'b1;
            else            e_g0 = 1'b1;
         end else begin
            e_g0 = m0_req;
            e_g1 = m1_req;
         end
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mb  <= 0;
         ev0 <= 1'b0;
         ev1 <= 1'b0;
         ed0 <= 16'h0;
         ed1 <= 16'h0;
      end else begin
         ev0 <= e_g0 && (m0_we == 2'b00);
         ev1 <= e_g1 && (m1_we == 2'b00);
         ed0 <= (e_g0 && (m0_we == 2'b00)) ? mmem[m0_addr] : 16'h0;
         ed1 <= (e_g1 && (m1_we == 2'b00)) ? mmem[m1_addr] : 16'h0;
         if (e_g0 && (m0_we != 2'b00)) mmem[m0_addr] <= merge(mmem[m0_addr], m0_wdata, m0_we);
         if (e_g1 && (m1_we != 2'b00)) mmem[m1_addr] <= merge(mmem[m1_addr], m1_wdata, m1_we);
         if (!m1_req || e_g1) mb <= 0;
         else if (e_g0)       mb <= mb + 1;
      end
   end

   always @(negedge clk) begin
      chk("m0_gnt", 32'(m0_gnt), 32'(e_g0));
      chk("m1_gnt", 32'(m1_gnt), 32'(e_g1));
      chk("enaB", 32'(enaB), 32'(e_g0 | e_g1));
      chk("weB", 32'(weB), e_g0 ? 32'(m0_we) : e_g1 ? 32'(m1_we) : 32'd0);
      chk("addrB", 32'(addrB), e_g0 ? 32'(m0_addr) : e_g1 ? 32'(m1_addr) : 32'd0);
      chk("dinB", 32'(dinB), e_g0 ? 32'(m0_wdata) : e_g1 ? 32'(m1_wdata) : 32'd0);
      chk("m0_rvalid", 32'(m0_rvalid), 32'(ev0));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(ev1));
      chk("m0_rdata", 32'(m0_rdata), 32'(ed0));
      chk("m1_rdata", 32'(m1_rdata), 32'(ed1));
      chk("rvalid_excl", 32'(m0_rvalid & m1_rvalid), 32'd0);
   end

   task automatic set0(input logic r, input logic [1:0] w, input logic [12:0] a,
                       input logic [15:0] d);
      m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
   endtask

   task automatic set1(input logic r, input logic [1:0] w, input logic [12:0] a,
                       input logic [15:0] d);
      m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int i0;
      int i1;
      for (int j = 0; j < 8192; j++) begin
         ram[j]  = 16'h0;
         mmem[j] = 16'h0;
      end
      rst = 1'b1;
      set0(1'b1, 2'b00, 13'h0, 16'h0);
      set1(1'b1, 2'b00, 13'h0, 16'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", 32'({m0_gnt, m1_gnt, enaB}), 32'd0);
      chk("rst_weB", 32'(weB), 32'd0);
      chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_m0_gnt", 32'(m0_gnt), 32'd1);
      step();
      set0(1'b0, 2'b00, 13'h0, 16'h0);
      set1(1'b0, 2'b00, 13'h0, 16'h0);
      step();

      // M0 full write then read back.
      set0(1'b1, 2'b11, 13'h0010, 16'hBEEF);
      step();
      set0(1'b1, 2'b00, 13'h0010, 16'h0);
      step();
      set0(1'b0, 2'b00, 13'h0, 16'h0);
      @(negedge clk);
      chk("wr_rd_rvalid", 32'(m0_rvalid), 32'd1);
      chk("wr_rd_rdata", 32'(m0_rdata), 32'hBEEF);
      chk("wr_rd_m1_rvalid", 32'(m1_rvalid), 32'd0);
      step();

      // Low-byte-only write merges into the existing word.
      set0(1'b1, 2'b11, 13'h0020, 16'h1234);
      step();
      set0(1'b1, 2'b01, 13'h0020, 16'hAB55);
      step();
      set0(1'b1, 2'b00, 13'h0020, 16'h0);
      step();
      set0(1'b0, 2'b00, 13'h0, 16'h0);
      @(negedge clk);
      chk("byte_wr_rdata", 32'(m0_rdata), 32'h1255);
      step();

      // Preload: M0 writes 0x200.., M1 writes 0x100..
      for (int j = 0; j < 12; j++) begin
         set0(1'b1, 2'b11, 13'(13'h200 + j), 16'(16'hC000 + j));
         step();
      end
      set0(1'b0, 2'b00, 13'h0, 16'h0);
      for (int j = 0; j < 4; j++) begin
         set1(1'b1, 2'b11, 13'(13'h100 + j), 16'(16'h5A00 + j));
         step();
      end
      set1(1'b0, 2'b00, 13'h0, 16'h0);
      step();

      // Continuous contention: M0 x4, M1 x1, repeating.
      i0 = 0;
      i1 = 0;
      for (int k = 0; k < 15; k++) begin
         set0(1'b1, 2'b00, 13'(13'h200 + i0), 16'h0);
         set1(1'b1, 2'b00, 13'(13'h100 + i1), 16'h0);
         @(negedge clk);
         chk("pat_m1_gnt", 32'(m1_gnt), 32'((k % 5) == 4));
         chk("pat_m0_gnt", 32'(m0_gnt), 32'((k % 5) != 4));
         if (m0_gnt) i0++;
         if (m1_gnt) i1++;
         step();
      end
      set0(1'b0, 2'b00, 13'h0, 16'h0);
      set1(1'b0, 2'b00, 13'h0, 16'h0);
      step();
      step();

      // Back-to-back alternation: M1 read, then M0 read.
      set1(1'b1, 2'b00, 13'h0100, 16'h0);
      step();
      set1(1'b0, 2'b00, 13'h0, 16'h0);
      set0(1'b1, 2'b00, 13'h0201, 16'h0);
      @(negedge clk);
      chk("alt_m1_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'b10);
      chk("alt_m1_rdata", 32'(m1_rdata), 32'h5A00);
      step();
      set0(1'b0, 2'b00, 13'h0, 16'h0);
      @(negedge clk);
      chk("alt_m0_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'b01);
      chk("alt_m0_rdata", 32'(m0_rdata), 32'hC001);
      step();

      // Reset between grant and read return discards the read.
      set1(1'b1, 2'b00, 13'h0101, 16'h0);
      @(negedge clk);
      chk("midrd_gnt", 32'(m1_gnt), 32'd1);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 set1(1'b0, 2'b00, 13'h0, 16'h0);
      step();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("midrd_no_rvalid", 32'(m1_rvalid), 32'd0);
         step();
      end

      // Reset clears a partially used burst window.
      set0(1'b1, 2'b00, 13'h0200, 16'h0);
      set1(1'b1, 2'b00, 13'h0102, 16'h0);
      step();
      step();
      step();
      @(negedge clk);
      #1 rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rst_burst_m1_gnt", 32'(m1_gnt), 32'(k == 4));
         step();
      end
      set0(1'b0, 2'b00, 13'h0, 16'h0);
      set1(1'b0, 2'b00, 13'h0, 16'h0);
      step();
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
